// File: rtl/xbar_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : xbar_pkg                                                  |
// | Brief    : Shared sizing and packed-slice helpers for the crossbar.  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package xbar_pkg;

    function automatic int bank_bits(input int nport);
        return $clog2(nport);
    endfunction

    function automatic int row_width(input int addrw, input int nport);
        return addrw - $clog2(nport);
    endfunction

    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/crossbar_nxn_write_rr_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : crossbar_nxn_write_rr_if                                  |
// | Brief    : Request and bank-side bundle of the write crossbar.       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface crossbar_nxn_write_rr_if
    import xbar_pkg::*;
#(
    parameter int NPORT = 4,
    parameter int ADDRW = 16,
    parameter int WL    = 32,
    parameter int CNTW  = 16
);
    localparam int c_RW = row_width(ADDRW, NPORT);

    logic                    ena;
    logic [NPORT-1:0]        req_valid;
    logic [NPORT*ADDRW-1:0]  req_addr;
    logic [NPORT*WL-1:0]     req_data;
    logic [NPORT-1:0]        req_ready;
    logic [NPORT-1:0]        bank_we;
    logic [NPORT*c_RW-1:0]   bank_addr;
    logic [NPORT*WL-1:0]     bank_data;
    logic [CNTW-1:0]         conflict_cnt;

    modport master (
        output ena, req_valid, req_addr, req_data,
        input  req_ready, bank_we, bank_addr, bank_data, conflict_cnt
    );

    modport slave (
        input  ena, req_valid, req_addr, req_data,
        output req_ready, bank_we, bank_addr, bank_data, conflict_cnt
    );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rr_arbiter                                                |
// | Brief    : Round-robin arbiter, one-hot grant, rotating priority.    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module rr_arbiter
    import xbar_pkg::*;
#(
    parameter int N = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         i_ena,
    input  wire logic [N-1:0] i_req,
    output logic      [N-1:0] o_gnt
);
    localparam int c_B = bank_bits(N);

    logic [c_B-1:0] r_ptr;
    logic [c_B-1:0] w_idx;
    logic [c_B-1:0] w_win;
    logic           w_found;

    // N is a power of two, so the index wraps naturally at c_B bits
    always_comb begin
        w_idx   = '0;
        w_win   = '0;
        w_found = 1'b0;
        o_gnt   = '0;
        for (int off = 0; off < N; off++) begin
            w_idx = r_ptr + c_B'(off);
            if (!w_found && i_req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
        if (i_ena && w_found) begin
            o_gnt[w_win] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_ena && w_found) begin
            r_ptr <= w_win + c_B'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/crossbar_nxn_write_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : crossbar_nxn_write_rr                                     |
// | Brief    : NxN write crossbar, per-bank round-robin, registered out. |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module crossbar_nxn_write_rr
    import xbar_pkg::*;
#(
    parameter int NPORT = 4,
    parameter int ADDRW = 16,
    parameter int WL    = 32,
    parameter int CNTW  = 16
) (
    input  wire logic               clk,
    input  wire logic               rst,
    crossbar_nxn_write_rr_if.slave  bus
);
    localparam int              c_B       = bank_bits(NPORT);
    localparam int              c_RW      = row_width(ADDRW, NPORT);
    localparam logic [CNTW-1:0] c_CNT_MAX = {CNTW{1'b1}};

    logic [NPORT-1:0][NPORT-1:0] w_req;
    logic [NPORT-1:0][NPORT-1:0] w_gnt;
    logic [NPORT-1:0][c_RW-1:0]  w_row;
    logic [NPORT-1:0][WL-1:0]    w_dat;
    logic [NPORT-1:0]            w_ready;
    logic                        w_arb_ena;
    logic                        w_conflict;

    logic [NPORT-1:0]            r_we;
    logic [NPORT*c_RW-1:0]       r_addr;
    logic [NPORT*WL-1:0]         r_data;
    logic [CNTW-1:0]             r_cnt;

    // Grants are suppressed while reset is high so no transfer is lost silently
    assign w_arb_ena = bus.ena & ~rst;

    always_comb begin
        w_req = '0;
        for (int b = 0; b < NPORT; b++) begin
            for (int p = 0; p < NPORT; p++) begin
                w_req[b][p] = bus.req_valid[p] &&
                              (bus.req_addr[slice_lo(p, ADDRW) +: c_B] == c_B'(b));
            end
        end
    end

    generate
        for (genvar b = 0; b < NPORT; b++) begin : g_bank
            rr_arbiter #(
                .N(NPORT)
            ) u_arb (
                .clk   (clk),
                .rst   (rst),
                .i_ena (w_arb_ena),
                .i_req (w_req[b]),
                .o_gnt (w_gnt[b])
            );
        end
    endgenerate

    always_comb begin
        w_ready = '0;
        w_row   = '0;
        w_dat   = '0;
        for (int b = 0; b < NPORT; b++) begin
            for (int p = 0; p < NPORT; p++) begin
                if (w_gnt[b][p]) begin
                    w_ready[p] = 1'b1;
                    w_row[b]   = bus.req_addr[slice_lo(p, ADDRW) + c_B +: c_RW];
                    w_dat[b]   = bus.req_data[slice_lo(p, WL) +: WL];
                end
            end
        end
    end

    assign w_conflict = bus.ena & (|(bus.req_valid & ~w_ready));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we   <= '0;
            r_addr <= '0;
            r_data <= '0;
            r_cnt  <= '0;
        end else begin
            for (int b = 0; b < NPORT; b++) begin
                r_we[b] <= |w_gnt[b];
                if (|w_gnt[b]) begin
                    r_addr[slice_lo(b, c_RW) +: c_RW] <= w_row[b];
                    r_data[slice_lo(b, WL) +: WL]     <= w_dat[b];
                end
            end
            if (w_conflict && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= r_cnt + CNTW'(1);
            end
        end
    end

    assign bus.req_ready    = w_ready;
    assign bus.bank_we      = r_we;
    assign bus.bank_addr    = r_addr;
    assign bus.bank_data    = r_data;
    assign bus.conflict_cnt = r_cnt;
endmodule
`default_nettype wire

// File: tb/tb_crossbar_nxn_write_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_crossbar_nxn_write_rr                                  |
// | Brief    : Scoreboard bench for the round-robin write crossbar.      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_crossbar_nxn_write_rr;
    localparam int NP = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam int RW = 14;

    typedef struct packed {
        logic [NP-1:0]    we;
        logic [NP*RW-1:0] addr;
        logic [NP*DW-1:0] data;
        logic [CW-1:0]    cnt;
    } exp_t;

    localparam logic [NP*AW-1:0] c_A_BANK2 = {16'h000E, 16'h000A, 16'h0006, 16'h0002};
    localparam logic [NP*DW-1:0] c_D_BANK2 = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0000};

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sbq[$];
    logic [1:0] m_ptr [NP];
    exp_t m_st;

    always #5 clk = ~clk;

    crossbar_nxn_write_rr_if #(.NPORT(NP), .ADDRW(AW), .WL(DW), .CNTW(CW)) xif ();

    crossbar_nxn_write_rr #(.NPORT(NP), .ADDRW(AW), .WL(DW), .CNTW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (xif)
    );

    // Drives one cycle of stimulus and predicts req_ready and the post-edge bank state
    task automatic apply(input logic r, input logic e, input logic [NP-1:0] v,
                         input logic [NP*AW-1:0] a, input logic [NP*DW-1:0] d,
                         output logic [NP-1:0] rdy);
        logic [1:0] w;
        logic       hit;
        rst = r; xif.ena = e; xif.req_valid = v; xif.req_addr = a; xif.req_data = d;
        rdy = '0;
        if (r) begin
            m_st = '0;
            for (int b = 0; b < NP; b++) m_ptr[b] = 2'd0;
        end else begin
            m_st.we = '0;
            for (int b = 0; b < NP; b++) begin
                hit = 1'b0;
                w   = 2'd0;
                for (int k = 0; k < NP; k++) begin
                    int p;
                    p = (int'(m_ptr[b]) + k) % NP;
                    if (e && !hit && v[p] && (a[p*AW +: 2] == 2'(b))) begin
                        hit = 1'b1;
                        w   = 2'(p);
                    end
                end
                if (hit) begin
                    rdy[w]                  = 1'b1;
                    m_st.we[b]              = 1'b1;
                    m_st.addr[b*RW +: RW]   = a[int'(w)*AW + 2 +: RW];
                    m_st.data[b*DW +: DW]   = d[int'(w)*DW +: DW];
                    m_ptr[b]                = w + 2'd1;
                end
            end
            if (e && (|(v & ~rdy)) && (m_st.cnt != 4'hF)) m_st.cnt = m_st.cnt + 4'd1;
        end
        sbq.push_back(m_st);
    endtask

    task automatic tick(output exp_t ex, output exp_t ob);
        @(posedge clk);
        #1;
        ex = sbq.pop_front();
        ob = {xif.bank_we, xif.bank_addr, xif.bank_data, xif.conflict_cnt};
    endtask

    task automatic do_reset();
        logic [NP-1:0] rdy;
        exp_t ex, ob;
        apply(1'b1, 1'b0, '0, '0, '0, rdy);
        tick(ex, ob);
    endtask

    task automatic test_reset();
        logic [NP-1:0] rdy;
        exp_t ex, ob;
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 1'b1, 4'hF, {16'h0003, 16'h0002, 16'h0001, 16'h0000}, '1, rdy);
            #1; n_vec++;
            if (xif.req_ready !== 4'h0) begin
                n_err++; $display("FAIL rst_ready got %b want 0000", xif.req_ready);
            end
            tick(ex, ob); n_vec++;
            if (ob !== ex) begin
                n_err++; $display("FAIL rst_state got %h want %h", ob, ex);
            end
        end
    endtask

    task automatic test_parallel();
        logic [NP-1:0] rdy;
        exp_t ex, ob;
        do_reset();
        apply(1'b0, 1'b1, 4'hF, {16'h0043, 16'h0032, 16'h0021, 16'h0010},
              {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000}, rdy);
        #1; n_vec++;
        if (xif.req_ready !== 4'b1111 || xif.req_ready !== rdy) begin
            n_err++; $display("FAIL par_ready got %b want 1111", xif.req_ready);
        end
        tick(ex, ob); n_vec++;
        if (ob !== ex || xif.bank_we !== 4'b1111 || xif.conflict_cnt !== 4'd0 ||
            xif.bank_addr !== {14'h010, 14'h00C, 14'h008, 14'h004}) begin
            n_err++; $display("FAIL par_bank got %h want %h", ob, ex);
        end
        apply(1'b0, 1'b1, 4'h0, '0, '0, rdy);
        #1;
        tick(ex, ob); n_vec++;
        if (ob !== ex || xif.bank_we !== 4'b0000 ||
            xif.bank_data !== {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000}) begin
            n_err++; $display("FAIL par_hold got %h want %h", ob, ex);
        end
    endtask

    task automatic test_contention();
        logic [NP-1:0] rdy, v;
        logic [NP-1:0] order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
        exp_t ex, ob;
        int   we2 = 0;
        do_reset();
        v = 4'hF;
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b1, v, c_A_BANK2, c_D_BANK2, rdy);
            #1; n_vec++;
            if (xif.req_ready !== order[i] || xif.req_ready !== rdy) begin
                n_err++; $display("FAIL cont_ready[%0d] got %b want %b", i, xif.req_ready, order[i]);
            end
            tick(ex, ob); n_vec++;
            if (ob !== ex) begin
                n_err++; $display("FAIL cont_bank[%0d] got %h want %h", i, ob, ex);
            end
            if (xif.bank_we[2]) we2++;
            v = v & ~rdy;
        end
        n_vec++;
        if (xif.conflict_cnt !== 4'd3 || we2 != 4) begin
            n_err++; $display("FAIL cont_total got cnt=%0d we2=%0d want cnt=3 we2=4", xif.conflict_cnt, we2);
        end
    endtask

    task automatic test_stream();
        logic [NP-1:0] rdy, want;
        exp_t ex, ob;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            want = (i % 2 == 0) ? 4'b0001 : 4'b0010;
            apply(1'b0, 1'b1, 4'b0011, {32'h0, 16'h0204, 16'h0100},
                  {64'h0, 32'h2000_0000 + 32'(i), 32'h1000_0000 + 32'(i)}, rdy);
            #1; n_vec++;
            if (xif.req_ready !== want || xif.req_ready !== rdy) begin
                n_err++; $display("FAIL stream_ready[%0d] got %b want %b", i, xif.req_ready, want);
            end
            tick(ex, ob); n_vec++;
            if (ob !== ex) begin
                n_err++; $display("FAIL stream_bank[%0d] got %h want %h", i, ob, ex);
            end
        end
    endtask

    task automatic test_ena_freeze();
        logic [NP-1:0] rdy, v;
        logic [6:0]    ena_tab = 7'b1110001;
        logic [NP-1:0] order [7] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0100, 4'b1000};
        exp_t ex, ob;
        do_reset();
        v = 4'hF;
        for (int i = 0; i < 7; i++) begin
            apply(1'b0, ena_tab[i], v, c_A_BANK2, c_D_BANK2, rdy);
            #1; n_vec++;
            if (xif.req_ready !== order[i] || xif.req_ready !== rdy) begin
                n_err++; $display("FAIL ena_ready[%0d] got %b want %b", i, xif.req_ready, order[i]);
            end
            tick(ex, ob); n_vec++;
            if (ob !== ex || (!ena_tab[i] && (xif.bank_we !== 4'h0 || xif.conflict_cnt !== 4'd1))) begin
                n_err++; $display("FAIL ena_bank[%0d] got %h want %h", i, ob, ex);
            end
            v = v & ~rdy;
        end
        n_vec++;
        if (xif.conflict_cnt !== 4'd3) begin
            n_err++; $display("FAIL ena_cnt got %0d want 3", xif.conflict_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [NP-1:0] rdy, v;
        exp_t ex, ob;
        do_reset();
        v = 4'hF;
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b1, v, c_A_BANK2, c_D_BANK2, rdy);
            #1;
            tick(ex, ob); n_vec++;
            if (ob !== ex) begin
                n_err++; $display("FAIL mid_pre[%0d] got %h want %h", i, ob, ex);
            end
            v = v & ~rdy;
        end
        apply(1'b1, 1'b1, 4'hF, c_A_BANK2, c_D_BANK2, rdy);
        #1; n_vec++;
        if (xif.req_ready !== 4'h0) begin
            n_err++; $display("FAIL mid_rst_ready got %b want 0000", xif.req_ready);
        end
        tick(ex, ob); n_vec++;
        if (ob !== ex || xif.bank_we !== 4'h0 || xif.conflict_cnt !== 4'd0) begin
            n_err++; $display("FAIL mid_rst_state got %h want %h", ob, ex);
        end
        apply(1'b0, 1'b1, 4'hF, c_A_BANK2, c_D_BANK2, rdy);
        #1; n_vec++;
        if (xif.req_ready !== 4'b0001 || xif.req_ready !== rdy) begin
            n_err++; $display("FAIL mid_first got %b want 0001", xif.req_ready);
        end
        tick(ex, ob); n_vec++;
        if (ob !== ex) begin
            n_err++; $display("FAIL mid_post got %h want %h", ob, ex);
        end
    endtask

    task automatic test_saturate();
        logic [NP-1:0] rdy;
        logic [CW-1:0] want;
        exp_t ex, ob;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            want = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
            apply(1'b0, 1'b1, 4'b0011, {32'h0, 16'h0005, 16'h0001},
                  {64'h0, 32'h5555_5555, 32'hAAAA_AAAA}, rdy);
            #1;
            tick(ex, ob); n_vec++;
            if (ob !== ex || xif.conflict_cnt !== want) begin
                n_err++; $display("FAIL sat[%0d] got cnt=%0d want %0d", i, xif.conflict_cnt, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_parallel();
        test_contention();
        test_stream();
        test_ena_freeze();
        test_reset_mid();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/crossbar_nxn_write_rr.md
CROSSBAR_NXN_WRITE_RR -- requirements
Module: crossbar_nxn_write_rr

Interface
REQ-001 SHALL have parameter NPORT, default 4, giving the port count and bank count; it must be a power of two, 2..16.
REQ-002 SHALL have parameter ADDRW, default 16, giving the word-address width.
REQ-003 SHALL have parameter WL, default 32, giving the data word width.
REQ-004 SHALL have parameter CNTW, default 16, giving the conflict-counter width.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk, input, 1 bit: the sole clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-008 SHALL have port ena, input, 1 bit: global enable; when low, no grants are made.
REQ-009 SHALL have port req_valid, input, NPORT bits: per-port write request.
REQ-010 SHALL have port req_addr, input, NPORT*ADDRW bits: packed per-port word address, with port p at slice [p*ADDRW +: ADDRW].
REQ-011 SHALL have port req_data, input, NPORT*WL bits: packed per-port write data.
REQ-012 SHALL have port req_ready, output, NPORT bits: per-port grant, combinational; the transfer occurs when valid and ready are both high at a clock edge.
REQ-013 SHALL have port bank_we, output, NPORT bits: registered per-bank write enable.
REQ-014 SHALL have port bank_addr, output, NPORT*(ADDRW-B) bits: registered per-bank row address, where B = log2(NPORT).
REQ-015 SHALL have port bank_data, output, NPORT*WL bits: registered per-bank write data.
REQ-016 SHALL have port conflict_cnt, output, CNTW bits: saturating count of cycles in which at least one valid request is denied.

Function
REQ-017 SHALL decode the bank of port p as req_addr[p][B-1:0] and the row as req_addr[p][ADDRW-1:B].
REQ-018 SHALL run one round-robin arbiter per bank among the ports that are valid and targeting that bank, granting at most one port per bank per cycle.
REQ-019 SHALL search from each bank's priority pointer ptr[b]; when ptr[b] = k, the search order is k, k+1, ..., k-1 (mod NPORT).
REQ-020 SHALL set ptr[b] to (winner+1) mod NPORT on the edge where bank b grants, and hold ptr[b] otherwise.
REQ-021 SHALL drive req_ready[p] = ena & req_valid[p] & (p is the winner of its bank); req_ready SHALL be 0 when req_valid[p] = 0.
REQ-022 SHALL give a latency of exactly 1 cycle: on the edge after a grant, bank_we[b] = 1 and bank_addr/bank_data carry the winner's row and data.
REQ-023 SHALL set bank_we[b] = 0 on the edge after any cycle with no grant for bank b; bank_addr/bank_data SHALL hold their last values in that case.
REQ-024 SHALL allow any number of banks to be granted in the same cycle; ports targeting distinct banks never stall.
REQ-025 SHALL require that a denied port holds valid, addr and data stable; under that rule, a port is granted within NPORT cycles of first assertion.
REQ-026 SHALL, when ena = 0: grant nothing, set bank_we to all-zero next cycle, hold the pointers, and not increment the counter.
REQ-027 SHALL increment conflict_cnt by 1 in each ena=1 cycle with any (valid & ~ready), saturating at 2^CNTW-1 with no wrap.
REQ-028 SHALL not expose a request that drops before being granted; it is discarded with no side effect.

Reset
REQ-029 SHALL, on the rst edge, set all ptr[b] = 0, bank_we = 0, bank_addr = 0, bank_data = 0 and conflict_cnt = 0.
REQ-030 SHALL force req_ready to all-zero while rst = 1; a request granted in the cycle reset asserts is lost, and bank_we SHALL be 0 after that edge.
REQ-031 SHALL use the reset values on the first cycle after rst deasserts; arbitration then restarts from port 0.

Structure
REQ-032 SHALL place B = $clog2(NPORT), the row-width calculation and the packed-slice index helpers in the shared package xbar_pkg.
REQ-033 SHALL implement the per-bank arbitration as sub-module rr_arbiter (NPORT request bits in, one-hot grant out, internal pointer), instantiated NPORT times in a generate loop.

Verification
REQ-034 SHALL cover this scenario (NPORT=4): addresses 0x0010/0x0021/0x0032/0x0043, all valid -> req_ready=4'b1111; next cycle bank_we=4'b1111, bank_addr = 0x004/0x008/0x00C/0x010, conflict_cnt unchanged.
REQ-035 SHALL cover this scenario: all 4 ports write bank 2 and are held after reset -> grants go to ports 0,1,2,3 on successive cycles; bank_we[2]=1 for 4 cycles; conflict_cnt=3.
REQ-036 SHALL cover this scenario: ports 0 and 1 stream continuously to bank 0 -> grants alternate 0,1,0,1; neither port waits more than 1 cycle.
REQ-037 SHALL cover this scenario: ena=0 for 3 cycles during the 4-way contention -> no grants, bank_we=0, pointers and count frozen; the order resumes unchanged.
REQ-038 SHALL cover this scenario: rst asserted mid-contention with ptr[2]=3 -> next cycle bank_we=0 and conflict_cnt=0; the first grant after release goes to port 0.
REQ-039 SHALL cover this scenario: CNTW=4 with persistent 2-way conflict for 20 cycles -> conflict_cnt stops at 15.
